// File: rtl/scc_pkg.sv
// Shared definitions for the SCC serial channel: character-length encodings,
// transmitter states and the baud/parity helper functions.
package scc_pkg;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_7 = 2'b01;
  localparam logic [1:0] BITS_6 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // One bit lasts the reload value plus the zero tick: 2*TC+4 = 2*(TC+2) ticks.
  function automatic logic [31:0] baud_reload(input logic [31:0] tc);
    return (tc << 1) + 32'd3;
  endfunction

  function automatic logic [3:0] bits_num(input logic [1:0] sel);
    logic [3:0] n;
    case (sel)
      BITS_5:  n = 4'd5;
      BITS_6:  n = 4'd6;
      BITS_7:  n = 4'd7;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] data_mask(input logic [7:0] d, input logic [1:0] sel);
    logic [7:0] m;
    case (sel)
      BITS_5:  m = 8'h1F;
      BITS_6:  m = 8'h3F;
      BITS_7:  m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return d & m;
  endfunction

  // Even parity is the XOR of the character bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] sel,
                                      input logic even);
    return (^data_mask(d, sel)) ^ ~even;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Small synchronous FIFO with registered full/empty flags, shared by the
// SCC transmit path (and later the receive path).
module serial_tx_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW:0]   cnt_r;
  logic [AW:0]   cnt_s;
  logic          full_r;
  logic          empty_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = en & push & ~full_r;
  assign do_pop_s  = en & pop & ~empty_r;
  assign rdata     = mem_r[rptr_r];
  assign full      = full_r;
  assign empty     = empty_r;

  // Occupancy after this tick; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_s = cnt_r;
    if (do_push_s && !do_pop_s) begin
      cnt_s = cnt_r + 1'b1;
    end else if (do_pop_s && !do_push_s) begin
      cnt_s = cnt_r - 1'b1;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Storage, pointers and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wptr_r  <= '0;
      rptr_r  <= '0;
      cnt_r   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else if (en) begin
      if (do_push_s) begin
        mem_r[wptr_r] <= wdata;
        wptr_r        <= wptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + 1'b1;
      end
      cnt_r   <= cnt_s;
      full_r  <= (cnt_s == FULL_CNT);
      empty_r <= (cnt_s == '0);
    end
  end

endmodule

// File: rtl/scc_serial_tx.sv
// SCC channel A asynchronous transmitter: 2-entry holding FIFO feeding a
// start/data/parity/stop serialiser timed by the baud time constant.
module scc_serial_tx
  import scc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TC_W       = 16
) (
  input  logic            clk,
  input  logic            _reset,
  input  logic            cep,
  input  logic            tx_enable,
  input  logic            send_break,
  input  logic [1:0]      bits_sel,
  input  logic            parity_en,
  input  logic            parity_even,
  input  logic            stop2,
  input  logic [TC_W-1:0] time_const,
  input  logic            wr,
  input  logic [7:0]      wdata,
  output logic            full,
  output logic            tx_empty,
  output logic            all_sent,
  output logic            serialOut
);

  localparam int CW = TC_W + 2;

  tx_state_e      state_r, state_s;
  logic [CW-1:0]  baud_r, baud_s;
  logic [CW-1:0]  reload_s;
  logic [7:0]     shift_r, shift_s;
  logic [2:0]     bit_idx_r, bit_idx_s;
  logic [2:0]     last_idx_s;
  logic           stop_idx_r, stop_idx_s;
  logic [1:0]     bits_sel_r, bits_sel_s;
  logic           par_en_r, par_en_s;
  logic           stop2_r, stop2_s;
  logic           par_bit_r, par_bit_s;
  logic           line_r, line_s;
  logic           frame_line_s;
  logic           load_s;
  logic           pop_s;
  logic [7:0]     head_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;

  serial_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (_reset),
    .en    (cep),
    .push  (wr),
    .pop   (pop_s),
    .wdata (wdata),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign reload_s   = CW'(baud_reload(32'(time_const)));
  assign last_idx_s = 3'(bits_num(bits_sel_r) - 4'd1);
  assign full       = fifo_full_s;
  assign tx_empty   = fifo_empty_s;
  assign all_sent   = fifo_empty_s & (state_r == ST_IDLE);
  assign serialOut  = line_r;

  // Framing FSM: next state, baud countdown, shifter and character setup.
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r;
    shift_s    = shift_r;
    bit_idx_s  = bit_idx_r;
    stop_idx_s = stop_idx_r;
    bits_sel_s = bits_sel_r;
    par_en_s   = par_en_r;
    stop2_s    = stop2_r;
    par_bit_s  = par_bit_r;
    load_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_enable && !fifo_empty_s && !send_break) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_START: begin
        if (baud_r != '0) begin
          baud_s = baud_r - 1'b1;
        end else begin
          baud_s  = reload_s;
          state_s = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_r != '0) begin
          baud_s = baud_r - 1'b1;
        end else begin
          baud_s = reload_s;
          if (bit_idx_r == last_idx_s) begin
            state_s = par_en_r ? ST_PARITY : ST_STOP;
          end else begin
            shift_s   = shift_r >> 1;
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_r != '0) begin
          baud_s = baud_r - 1'b1;
        end else begin
          baud_s  = reload_s;
          state_s = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_r != '0) begin
          baud_s = baud_r - 1'b1;
        end else if (stop2_r && !stop_idx_r) begin
          baud_s     = reload_s;
          stop_idx_s = 1'b1;
        end else if (tx_enable && !fifo_empty_s) begin
          load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Framing inputs are captured per character so mid-character changes cannot corrupt it.
    if (load_s) begin
      shift_s    = data_mask(head_s, bits_sel);
      bits_sel_s = bits_sel;
      par_en_s   = parity_en;
      stop2_s    = stop2;
      par_bit_s  = parity_bit(head_s, bits_sel, parity_even);
      baud_s     = reload_s;
      bit_idx_s  = 3'd0;
      stop_idx_s = 1'b0;
      state_s    = ST_START;
    end else begin
      state_s = state_s;
    end
  end

  assign pop_s = load_s;

  // Line level follows the state being entered so each level lasts exactly one bit period.
  always_comb begin
    frame_line_s = 1'b1;
    case (state_s)
      ST_IDLE:   frame_line_s = 1'b1;
      ST_START:  frame_line_s = 1'b0;
      ST_DATA:   frame_line_s = shift_s[0];
      ST_PARITY: frame_line_s = par_bit_s;
      ST_STOP:   frame_line_s = 1'b1;
      default:   frame_line_s = 1'b1;
    endcase
    if (send_break) begin
      line_s = 1'b0;
    end else begin
      line_s = frame_line_s;
    end
  end

  // Serialiser state registers; cep gates every update.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_r    <= ST_IDLE;
      baud_r     <= '0;
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      bits_sel_r <= BITS_8;
      par_en_r   <= 1'b0;
      stop2_r    <= 1'b0;
      par_bit_r  <= 1'b0;
      line_r     <= 1'b1;
    end else if (cep) begin
      state_r    <= state_s;
      baud_r     <= baud_s;
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      stop_idx_r <= stop_idx_s;
      bits_sel_r <= bits_sel_s;
      par_en_r   <= par_en_s;
      stop2_r    <= stop2_s;
      par_bit_r  <= par_bit_s;
      line_r     <= line_s;
    end
  end

endmodule

// File: doc/scc_serial_tx.md
Name: scc_serial_tx

Overview:
- Asynchronous serial transmitter for SCC channel A.
- Drives the board-level serialOut pin, which is currently tied low; it is the transmit-direction counterpart of the serialIn receive path.
- Accepts bytes from the SCC transmit-buffer write path through a 2-entry holding FIFO.
- Serialises each byte as start / 5-8 data bits LSB first / optional parity / 1 or 2 stop bits, at a bit rate set by the SCC baud-rate time constant.

Parameters:
- FIFO_DEPTH, 2, holding-buffer entries (power of two, ≥2).
- TC_W, 16, width of the baud time constant.

Ports:
- clk  input  1  system clock.
- _reset  input  1  asynchronous active-low reset.
- cep  input  1  clock enable; all timing counts cep ticks.
- tx_enable  input  1  transmitter enable (WR5 Tx Enable).
- send_break  input  1  force line to space (WR5 Send Break).
- bits_sel  input  2  data bits: 00=5, 01=7, 10=6, 11=8 (SCC WR5 encoding).
- parity_en  input  1  append parity bit.
- parity_even  input  1  1=even, 0=odd parity.
- stop2  input  1  0=1 stop bit, 1=2 stop bits.
- time_const  input  TC_W  baud time constant TC.
- wr  input  1  write strobe for wdata (sampled when cep=1).
- wdata  input  8  byte to send.
- full  output  1  FIFO full; writes are ignored while full.
- tx_empty  output  1  FIFO empty (RR0 Tx Buffer Empty).
- all_sent  output  1  FIFO empty and shifter idle (RR1 All Sent).
- serialOut  output  1  TxD line, idle mark = 1.

Behaviour:
- Reset (async, _reset=0): FIFO pointers 0, state IDLE, baud counter 0, serialOut=1, full=0, tx_empty=1, all_sent=1.
- Bit period: 2*(TC+2) cep ticks. The counter reloads with 2*TC+3 and counts down to 0.
- time_const changes take effect at the next bit boundary.
- FIFO writes:
  - wr & cep & !full pushes wdata; wr while full is dropped with no state change.
  - A write and a pop in the same tick are both honoured; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. full/tx_empty are registered, updated the tick after the event.
- State machine:
  - IDLE: serialOut=1. If tx_enable & FIFO not empty & !send_break, pop the head into the shifter, latch the framing inputs (bits_sel, parity_en, parity_even, stop2) for this character, load the baud counter and go to START. The first start-bit edge appears on serialOut within 2 cep ticks of the FIFO becoming non-empty.
  - START: drive 0 for one bit period, then DATA.
  - DATA: drive shifter[0] and shift right each period. After N bits (N = 5/6/7/8 from the latched bits_sel) go to PARITY if parity_en, else STOP.
  - PARITY: drive XOR of the N data bits, inverted when parity_even=0 (odd parity). Then STOP.
  - STOP: drive 1 for 1 or 2 periods per latched stop2. Then go to START directly if FIFO not empty & tx_enable (back-to-back, no idle gap), else IDLE.
- all_sent = tx_empty & state==IDLE.
- tx_enable deasserted mid-character: the current character completes; no new character starts.
- send_break:
  - Forces serialOut=0 in any state, overriding the line.
  - In IDLE it blocks starts.
  - Mid-character, the framing continues internally but the line stays 0. On release the line returns to the state-driven value.
- Data bits above N in wdata are ignored.
- cep=0 freezes all state except async reset.
- serialOut is registered: no combinational path from inputs.

Decomposition:
- Shared package scc_pkg holds:
  - the bits_sel encodings;
  - state enumeration IDLE/START/DATA/PARITY/STOP;
  - the baud reload function 2*TC+3.
- One sub-module, serial_tx_fifo: a synchronous FIFO with push/pop/full/empty, reusable by the future receive path.

Test Plan:
- Basic frame: TC=0 (4-tick bit), 8N1, write 0x55 → serialOut shows 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each level held 4 cep ticks; all_sent returns to 1 after the stop bit.
- Parity/length: 7 bits, even parity, 2 stop bits, write 0xC3 (data 1000011) → 7 data bits 1,1,0,0,0,0,1, parity 1, two stop periods; bit 7 of wdata not sent.
- Buffering: write 0x01, 0x02, 0x03 on consecutive cep ticks → full asserts after the third write is queued. A fourth write while full is dropped. Characters go out back-to-back with no mark gap between the stop bit and the next start bit.
- Break: assert send_break mid-data for 3 bit periods → serialOut=0 throughout. On release the line returns to the current framing value; the character count is unchanged.
- tx_enable drop: deassert during the second character with one byte still queued → the second character completes and the line idles at 1. tx_empty=0 while the byte waits; on re-enable the queued byte transmits.
- Async reset mid-character: pull _reset low without a clock edge → serialOut=1, tx_empty=1, all_sent=1 immediately, and the FIFO is emptied.
